// File: rtl/time_alarm_core.sv
// time_alarm_core
//   Timekeeping and alarm core. Divides clk down to a one-second tick, keeps
//   a 24 h BCD hh:mm:ss time that can be set with key pulses, holds
//   NUM_ALARMS programmable alarm slots, runs the ring/snooze state machine
//   and produces the hourly chime window.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active low
//   set_mode   1 = time-set mode (time frozen, divider held), 0 = run
//   inc_hr     pulse: hours +1 mod 24 (set mode only)
//   inc_min    pulse: minutes +1 mod 60, no carry (set mode only)
//   clr_sec    pulse: seconds := 00 (set mode only)
//   alarm_we   pulse: write {alarm_on, alarm_hh, alarm_mm} to slot alarm_sel
//   alarm_sel  slot index for the write
//   alarm_hh   BCD hour for the write (00..23)
//   alarm_mm   BCD minute for the write (00..59)
//   alarm_on   enable bit for the write
//   stop       pulse: silence the alarm (ringing or snoozing)
//   snooze     pulse: snooze a ringing alarm
//   chime_en   enables the hourly chime
//   shi        BCD hours 00..23
//   fen        BCD minutes 00..59
//   miao       BCD seconds 00..59
//   sec_tick   one-cycle pulse per second (run mode only)
//   ring       alarm sounding
//   ring_idx   slot that triggered the current ring/snooze
//   snoozing   snooze in progress
//   chime      hourly chime active (last five seconds of each hour)
module time_alarm_core #(
  parameter int TICK_DIV    = 50000000,
  parameter int NUM_ALARMS  = 4,
  parameter int AW          = 2,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_mode,
  input  logic          inc_hr,
  input  logic          inc_min,
  input  logic          clr_sec,
  input  logic          alarm_we,
  input  logic [AW-1:0] alarm_sel,
  input  logic [7:0]    alarm_hh,
  input  logic [7:0]    alarm_mm,
  input  logic          alarm_on,
  input  logic          stop,
  input  logic          snooze,
  input  logic          chime_en,
  output logic [7:0]    shi,
  output logic [7:0]    fen,
  output logic [7:0]    miao,
  output logic          sec_tick,
  output logic          ring,
  output logic [AW-1:0] ring_idx,
  output logic          snoozing,
  output logic          chime
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  // BCD increment with wrap to 00 once the value reaches top.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Both digits must be decimal; for valid BCD a plain byte compare orders
  // the same way as the decimal value, so the range check is a byte compare.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] top);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= top);
  endfunction

  logic [DIV_W-1:0]      div_q;
  logic [7:0]            hh_q, mm_q, ss_q;
  logic [7:0]            hh_d, mm_d, ss_d;
  logic [NUM_ALARMS-1:0] slot_on_q;
  logic [7:0]            slot_hh_q [NUM_ALARMS];
  logic [7:0]            slot_mm_q [NUM_ALARMS];
  logic [(1<<AW)-1:0]    sel_exists;
  logic                  wr_ok;
  logic                  match_hit;
  logic [AW-1:0]         match_idx;
  logic                  kill;
  state_t                state_q, state_d;
  logic [15:0]           sec_cnt_q;
  logic [AW-1:0]         ring_idx_q;
  logic                  ring_done, snooze_done;

  // ---- one-second divider ----
  assign sec_tick = !set_mode && (div_q == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      div_q <= '0;
    else if (set_mode || sec_tick)
      div_q <= '0;
    else
      div_q <= div_q + 1'b1;
  end

  // ---- time of day: carry chain in run mode, key pulses in set mode ----
  always_comb begin
    hh_d = hh_q;
    mm_d = mm_q;
    ss_d = ss_q;
    if (sec_tick) begin
      ss_d = bcd_inc(ss_q, 8'h59);
      if (ss_q == 8'h59) begin
        mm_d = bcd_inc(mm_q, 8'h59);
        if (mm_q == 8'h59)
          hh_d = bcd_inc(hh_q, 8'h23);
      end
    end else if (set_mode) begin
      if (inc_hr)
        hh_d = bcd_inc(hh_q, 8'h23);
      if (inc_min)
        mm_d = bcd_inc(mm_q, 8'h59);
      if (clr_sec)
        ss_d = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hh_q <= 8'h00;
      mm_q <= 8'h00;
      ss_q <= 8'h00;
    end else begin
      hh_q <= hh_d;
      mm_q <= mm_d;
      ss_q <= ss_d;
    end
  end

  assign shi  = hh_q;
  assign fen  = mm_q;
  assign miao = ss_q;

  // ---- alarm slots ----
  // Table of which select codes map to a real slot; AW may be wider than
  // needed for NUM_ALARMS.
  always_comb begin
    sel_exists = '0;
    for (int i = 0; i < (1 << AW); i++)
      sel_exists[i] = (i < NUM_ALARMS);
  end

  assign wr_ok = alarm_we && sel_exists[alarm_sel] &&
                 bcd_ok(alarm_hh, 8'h23) && bcd_ok(alarm_mm, 8'h59);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_on_q <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot_hh_q[i] <= 8'h00;
        slot_mm_q[i] <= 8'h00;
      end
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (alarm_sel == AW'(i)) begin
          slot_on_q[i] <= alarm_on;
          slot_hh_q[i] <= alarm_hh;
          slot_mm_q[i] <= alarm_mm;
        end
      end
    end
  end

  // Match against the time about to become visible, only on the tick that
  // lands on second 00. Scanning downwards leaves the lowest index winning.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (slot_on_q[i] && (slot_hh_q[i] == hh_d) && (slot_mm_q[i] == mm_d)) begin
        match_hit = 1'b1;
        match_idx = AW'(i);
      end
    end
    if (!(sec_tick && (ss_d == 8'h00)))
      match_hit = 1'b0;
  end

  // Disabling the slot that owns the current ring/snooze cancels it.
  assign kill = wr_ok && !alarm_on && (alarm_sel == ring_idx_q);

  // ---- ring / snooze state machine ----
  assign ring_done   = sec_tick && (sec_cnt_q == 16'(RING_SECS - 1));
  assign snooze_done = sec_tick && (sec_cnt_q == 16'(SNOOZE_SECS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (match_hit)
          state_d = ST_RING;
      end
      ST_RING: begin
        if (set_mode || stop || kill)
          state_d = ST_IDLE;
        else if (snooze)
          state_d = ST_SNOOZE;
        else if (ring_done)
          state_d = ST_IDLE;
      end
      ST_SNOOZE: begin
        if (set_mode || stop || kill)
          state_d = ST_IDLE;
        else if (snooze_done)
          state_d = ST_RING;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ring     = (state_q == ST_RING);
    snoozing = (state_q == ST_SNOOZE);
  end

  // Seconds counter restarts on every state change; ring_idx is latched only
  // when a new ring starts so it survives snooze and idles with its last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_cnt_q  <= 16'd0;
      ring_idx_q <= '0;
    end else begin
      if ((state_q == ST_IDLE) && (state_d == ST_RING))
        ring_idx_q <= match_idx;
      if (state_d != state_q)
        sec_cnt_q <= 16'd0;
      else if (sec_tick)
        sec_cnt_q <= sec_cnt_q + 16'd1;
    end
  end

  assign ring_idx = ring_idx_q;

  // ---- hourly chime: last five seconds of every hour ----
  assign chime = chime_en && !set_mode && (mm_q == 8'h59) &&
                 (ss_q >= 8'h55) && (ss_q <= 8'h59);

endmodule

// File: tb/tb_time_alarm_core.sv
// Self-checking bench for time_alarm_core. A behavioural model keeps time
// as seconds-of-day and alarms as minutes-of-day; every cycle the DUT
// outputs are compared with the model, plus a few fixed-value checks.
module tb_time_alarm_core;

  localparam int TICK_DIV    = 4;
  localparam int NUM_ALARMS  = 5;
  localparam int AW          = 3;
  localparam int RING_SECS   = 3;
  localparam int SNOOZE_SECS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          set_mode = 1'b0, inc_hr = 1'b0, inc_min = 1'b0, clr_sec = 1'b0;
  logic          alarm_we = 1'b0, alarm_on = 1'b0;
  logic [AW-1:0] alarm_sel = '0;
  logic [7:0]    alarm_hh = 8'h00, alarm_mm = 8'h00;
  logic          stop = 1'b0, snooze = 1'b0, chime_en = 1'b0;
  logic [7:0]    shi, fen, miao;
  logic          sec_tick, ring, snoozing, chime;
  logic [AW-1:0] ring_idx;

  always #5 clk = ~clk;

  time_alarm_core #(
    .TICK_DIV(TICK_DIV), .NUM_ALARMS(NUM_ALARMS), .AW(AW),
    .RING_SECS(RING_SECS), .SNOOZE_SECS(SNOOZE_SECS)
  ) dut (
    .clk(clk), .rst(rst), .set_mode(set_mode), .inc_hr(inc_hr),
    .inc_min(inc_min), .clr_sec(clr_sec), .alarm_we(alarm_we),
    .alarm_sel(alarm_sel), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
    .alarm_on(alarm_on), .stop(stop), .snooze(snooze), .chime_en(chime_en),
    .shi(shi), .fen(fen), .miao(miao), .sec_tick(sec_tick), .ring(ring),
    .ring_idx(ring_idx), .snoozing(snoozing), .chime(chime)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---- behavioural model ----
  int m_sec, m_div, m_state, m_left, m_idx;  // m_state: 0 idle, 1 ring, 2 snooze
  bit m_on [NUM_ALARMS];
  int m_hm [NUM_ALARMS];

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) * 16) + (n % 10));
  endfunction

  function automatic int bcd2int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit byte_ok(input logic [7:0] b, input int maxv);
    return (int'(b[7:4]) <= 9) && (int'(b[3:0]) <= 9) && (bcd2int(b) <= maxv);
  endfunction

  task automatic model_reset();
    m_sec = 0; m_div = 0; m_state = 0; m_left = 0; m_idx = 0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      m_on[i] = 1'b0;
      m_hm[i] = 0;
    end
  endtask

  task automatic model_update();
    bit t, wv, kill;
    int ns, h, m, s, hit, sel;
    t = !set_mode && (m_div == TICK_DIV - 1);
    h = m_sec / 3600; m = (m_sec / 60) % 60; s = m_sec % 60;
    if (t)
      ns = (m_sec + 1) % 86400;
    else if (set_mode) begin
      if (inc_hr)  h = (h + 1) % 24;
      if (inc_min) m = (m + 1) % 60;
      if (clr_sec) s = 0;
      ns = h * 3600 + m * 60 + s;
    end else
      ns = m_sec;
    hit = -1;
    if (t && (ns % 60 == 0))
      for (int i = NUM_ALARMS - 1; i >= 0; i--)
        if (m_on[i] && m_hm[i] == ns / 60) hit = i;
    sel  = int'(alarm_sel);
    wv   = alarm_we && (sel < NUM_ALARMS) && byte_ok(alarm_hh, 23) && byte_ok(alarm_mm, 59);
    kill = wv && !alarm_on && (sel == m_idx);
    case (m_state)
      0: if (hit >= 0) begin m_state = 1; m_left = RING_SECS; m_idx = hit; end
      1: begin
        if (set_mode || stop || kill) m_state = 0;
        else if (snooze) begin m_state = 2; m_left = SNOOZE_SECS; end
        else if (t) begin
          m_left--;
          if (m_left == 0) m_state = 0;
        end
      end
      default: begin
        if (set_mode || stop || kill) m_state = 0;
        else if (t) begin
          m_left--;
          if (m_left == 0) begin m_state = 1; m_left = RING_SECS; end
        end
      end
    endcase
    if (wv) begin
      m_on[sel] = alarm_on;
      m_hm[sel] = bcd2int(alarm_hh) * 60 + bcd2int(alarm_mm);
    end
    m_div = (set_mode || t) ? 0 : m_div + 1;
    m_sec = ns;
  endtask

  task automatic compare_all();
    bit e_tick, e_chime;
    e_tick  = !set_mode && (m_div == TICK_DIV - 1);
    e_chime = chime_en && !set_mode && ((m_sec / 60) % 60 == 59) && (m_sec % 60 >= 55);
    check("shi",      32'(shi),      32'(to_bcd(m_sec / 3600)));
    check("fen",      32'(fen),      32'(to_bcd((m_sec / 60) % 60)));
    check("miao",     32'(miao),     32'(to_bcd(m_sec % 60)));
    check("sec_tick", 32'(sec_tick), 32'(e_tick));
    check("ring",     32'(ring),     32'(m_state == 1));
    check("ring_idx", 32'(ring_idx), m_idx);
    check("snoozing", 32'(snoozing), 32'(m_state == 2));
    check("chime",    32'(chime),    32'(e_chime));
  endtask

  // One clock: compare just after the falling edge, advance the model on the
  // rising edge, then drop all single-cycle pulses.
  task automatic step();
    #1 compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
    inc_hr = 1'b0; inc_min = 1'b0; clr_sec = 1'b0;
    alarm_we = 1'b0; stop = 1'b0; snooze = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    int seen = 0;
    for (int k = 0; k < (n + 1) * TICK_DIV && seen < n; k++) begin
      #1 if (sec_tick) seen++;
      step();
    end
    check("tick_wait", 32'(seen), 32'(n));
  endtask

  // Enter set mode and dial hh:mm:00; set_mode is left at 1.
  task automatic set_time(input int h, input int m);
    set_mode = 1'b1;
    clr_sec = 1'b1;
    step();
    for (int k = 0; k < 24 && (m_sec / 3600) != h; k++) begin
      inc_hr = 1'b1;
      step();
    end
    for (int k = 0; k < 60 && ((m_sec / 60) % 60) != m; k++) begin
      inc_min = 1'b1;
      step();
    end
  endtask

  task automatic write_alarm(input int sel, input logic [7:0] hh, input logic [7:0] mm, input logic on);
    alarm_we = 1'b1; alarm_sel = AW'(sel); alarm_hh = hh; alarm_mm = mm; alarm_on = on;
    step();
  endtask

  task automatic expect_hms(input string tag, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    #1;
    check({tag, "_hh"}, 32'(shi),  32'(h));
    check({tag, "_mm"}, 32'(fen),  32'(m));
    check({tag, "_ss"}, 32'(miao), 32'(s));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1 compare_all();
    @(negedge clk);
    rst = 1'b1;

    // first tick after reset on the TICK_DIV-th cycle
    repeat (TICK_DIV) step();
    #1 check("first_sec", 32'(miao), 32'h01);

    // day wrap
    set_time(23, 59);
    set_mode = 1'b0;
    run_ticks(59);
    expect_hms("pre_wrap", 8'h23, 8'h59, 8'h59);
    run_ticks(1);
    expect_hms("wrap", 8'h00, 8'h00, 8'h00);

    // set-mode keys
    set_time(9, 58);
    set_mode = 1'b0;
    run_ticks(37);
    expect_hms("run37", 8'h09, 8'h58, 8'h37);
    set_mode = 1'b1;
    inc_min = 1'b1; step();
    inc_min = 1'b1; step();
    inc_min = 1'b1; clr_sec = 1'b1; step();
    expect_hms("inc_min3", 8'h09, 8'h01, 8'h00);
    inc_hr = 1'b1; inc_min = 1'b1; step();
    expect_hms("inc_both", 8'h10, 8'h02, 8'h00);
    set_mode = 1'b0;
    inc_hr = 1'b1; inc_min = 1'b1; clr_sec = 1'b1; step();
    expect_hms("run_keys", 8'h10, 8'h02, 8'h00);

    // two slots at 07:30, lowest index wins, auto-stop
    write_alarm(1, 8'h07, 8'h30, 1'b1);
    write_alarm(3, 8'h07, 8'h30, 1'b1);
    set_time(7, 29);
    set_mode = 1'b0;
    run_ticks(59);
    #1 check("pre_ring", 32'(ring), 32'h0);
    run_ticks(1);
    #1 check("ring_on", 32'(ring), 32'h1);
    check("ring_idx1", 32'(ring_idx), 32'h1);
    run_ticks(2);
    #1 check("ring_hold", 32'(ring), 32'h1);
    run_ticks(1);
    #1 check("ring_auto_off", 32'(ring), 32'h0);

    // snooze and re-ring, then stop+snooze together
    set_time(7, 29);
    set_mode = 1'b0;
    run_ticks(60);
    snooze = 1'b1; step();
    #1 check("snz_ring", 32'(ring), 32'h0);
    check("snz_flag", 32'(snoozing), 32'h1);
    run_ticks(2);
    #1 check("resnz_ring", 32'(ring), 32'h1);
    check("resnz_idx", 32'(ring_idx), 32'h1);
    stop = 1'b1; snooze = 1'b1; step();
    #1 check("stop_wins_ring", 32'(ring), 32'h0);
    check("stop_wins_snz", 32'(snoozing), 32'h0);

    // rejected writes leave slot 2 disabled
    write_alarm(2, 8'h24, 8'h31, 1'b1);
    write_alarm(2, 8'h07, 8'h5A, 1'b1);
    write_alarm(6, 8'h07, 8'h31, 1'b1);
    set_time(7, 30);
    set_mode = 1'b0;
    run_ticks(60);
    #1 check("bad_write_no_ring", 32'(ring), 32'h0);

    // disabling the ringing slot cancels the ring
    set_time(7, 29);
    set_mode = 1'b0;
    run_ticks(60);
    #1 check("pre_kill", 32'(ring), 32'h1);
    write_alarm(1, 8'h07, 8'h30, 1'b0);
    #1 check("kill", 32'(ring), 32'h0);

    // hourly chime
    chime_en = 1'b1;
    set_time(10, 59);
    set_mode = 1'b0;
    run_ticks(54);
    #1 check("chime_54", 32'(chime), 32'h0);
    run_ticks(1);
    #1 check("chime_55", 32'(chime), 32'h1);
    run_ticks(4);
    #1 check("chime_59", 32'(chime), 32'h1);
    run_ticks(1);
    #1 check("chime_00", 32'(chime), 32'h0);
    chime_en = 1'b0;
    set_time(10, 59);
    set_mode = 1'b0;
    run_ticks(57);
    #1 check("chime_dis", 32'(chime), 32'h0);

    // randomized traffic with alarms aimed at the coming minute
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        rst = 1'b0;
        model_reset();
        #1 compare_all();
        #2 rst = 1'b1;
        @(negedge clk);
      end
      if ($urandom_range(0, 149) == 0) set_mode = ~set_mode;
      if ($urandom_range(0, 99) == 0) chime_en = ~chime_en;
      inc_hr  = ($urandom_range(0, 7) == 0);
      inc_min = ($urandom_range(0, 7) == 0);
      clr_sec = ($urandom_range(0, 7) == 0);
      stop    = ($urandom_range(0, 59) == 0);
      snooze  = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 19) == 0) begin
        alarm_we  = 1'b1;
        alarm_sel = AW'($urandom_range(0, 7));
        alarm_on  = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) begin
          alarm_hh = 8'($urandom_range(0, 255));
          alarm_mm = 8'($urandom_range(0, 255));
        end else begin
          alarm_hh = to_bcd(m_sec / 3600);
          alarm_mm = to_bcd(((m_sec / 60) + 1) % 60);
        end
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
